// File: rtl/mat_result_drain.sv
// Purpose     : captures a flattened N x N result matrix in one cycle and streams it
//               out one 2W-bit element per beat, tagged with row/col and a last flag.
// Latency     : 1 clock from capture to the first beat; one beat per clock while i_ready is high.
// Backpressure: i_ready low holds the current beat stable. o_C_ready is high only when idle
//               or when the final beat is being accepted. A matrix offered while o_C_ready is
//               low is dropped and flagged on o_overrun.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_C_valid, i_C, o_C_ready   matrix capture handshake; element (0,0) sits at the MSB end
//   o_data, o_row, o_col        current element and its indices
//   o_valid, o_last, i_ready    output beat handshake; o_last marks the N*N-th beat
//   i_clr, o_overrun            sticky overrun flag and its synchronous clear
//
// Build option:
//   DRAIN_COL_MAJOR_EN  when defined, drains in column-major order (o_row fastest).
//                       When undefined, drains in row-major order (o_col fastest).
module mat_result_drain #(
    parameter  int W  = 32,
    parameter  int N  = 3,
    localparam int CW = $clog2(N)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_C_valid,
    input  logic [2*W*N*N-1:0]   i_C,
    output logic                 o_C_ready,
    output logic [2*W-1:0]       o_data,
    output logic [CW-1:0]        o_row,
    output logic [CW-1:0]        o_col,
    output logic                 o_valid,
    output logic                 o_last,
    input  logic                 i_ready,
    input  logic                 i_clr,
    output logic                 o_overrun
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*W*N*N-1:0]   cap_q, cap_d;
    logic [CW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 overrun_q, overrun_d;

    logic                 accept;
    logic                 at_end;
    logic                 c_ready;
    logic                 capture;

    // Element view of the capture register.
    // Element k = r*N + c is counted from the MSB end of the bus.
    logic [2*W-1:0]       elem [N][N];

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign elem[r][c] = cap_q[2*W*(N*N - (r*N + c)) - 1 -: 2*W];
        end
    end

    // Both drain orders finish on (N-1,N-1), so one end-of-matrix test serves both.
    assign at_end  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign o_valid = (state_q == STREAM);
    assign o_last  = o_valid && at_end;
    assign accept  = o_valid && i_ready;

    // The last-beat accept also opens the capture port.
    // This lets back-to-back matrices stream without a bubble.
    assign c_ready   = (state_q == IDLE) || (accept && at_end);
    assign capture   = i_C_valid && c_ready;
    assign o_C_ready = c_ready;

    // The output element is a pure mux of registered state.
    // It therefore holds stable whenever the counters hold.
    // Reset clears cap_q, so o_data reads zero out of reset.
    assign o_row     = row_q;
    assign o_col     = col_q;
    assign o_data    = elem[row_q][col_q];
    assign o_overrun = overrun_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cap_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    cap_d   = i_C;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (at_end) begin
                        row_d = '0;
                        col_d = '0;
                        if (capture) begin
                            cap_d = i_C;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
`ifdef DRAIN_COL_MAJOR_EN
                        if (row_q == LAST_IDX) begin
                            row_d = '0;
                            col_d = col_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
`else
                        if (col_q == LAST_IDX) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A dropped matrix takes priority over a simultaneous clear.
        if (i_C_valid && !c_ready) begin
            overrun_d = 1'b1;
        end else if (i_clr) begin
            overrun_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_mat_result_drain.sv
// Purpose     : self-checking bench for mat_result_drain (W=32, N=3), using a vector table plus a scoreboard.
// Latency     : expects the first beat 1 clock after capture and one beat per clock under constant ready.
// Backpressure: toggles i_ready and checks that stalled beats hold.
module tb_mat_result_drain;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int EW = 2 * W;
    localparam int MW = EW * N * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_valid;
    logic [MW-1:0] c_bus;
    logic          c_ready;
    logic [EW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          vld;
    logic          last;
    logic          rdy;
    logic          clr;
    logic          overrun;

    always #5 clk = ~clk;

    mat_result_drain #(.W(W), .N(N)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_C_valid (c_valid),
        .i_C       (c_bus),
        .o_C_ready (c_ready),
        .o_data    (data),
        .o_row     (row),
        .o_col     (col),
        .o_valid   (vld),
        .o_last    (last),
        .i_ready   (rdy),
        .i_clr     (clr),
        .o_overrun (overrun)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
        logic        c_ready;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    vec_t  tbl [9];
    exp_t  sb_q [$];
    exp_t  e;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    acc_cnt  = 0;
    bit    sb_en    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [MW-1:0] build(input int base);
        logic [MW-1:0] v;
        v = '0;
        for (int k = 0; k < N*N; k++) v[EW*(N*N-k)-1 -: EW] = 64'(base + k + 1);
        return v;
    endfunction

    task automatic push_matrix(input int base);
        exp_t x;
        int   r;
        int   c;
        for (int j = 0; j < N*N; j++) begin
`ifdef DRAIN_COL_MAJOR_EN
            r = j % N;
            c = j / N;
`else
            r = j / N;
            c = j % N;
`endif
            x.data = 64'(base + r*N + c + 1);
            x.row  = 2'(r);
            x.col  = 2'(c);
            x.last = (j == N*N-1);
            sb_q.push_back(x);
        end
    endtask

    // Drive a one-cycle capture of the matrix whose elements are base+1 .. base+9.
    task automatic capture(input int base);
        c_bus   = build(base);
        c_valid = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) timeout_fail(name);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: checks accepted beats in order and checks that stalled beats hold.
    logic        stall_p = 1'b0;
    logic [63:0] p_data;
    logic [1:0]  p_row;
    logic [1:0]  p_col;
    logic        p_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p && vld) begin
                chk("stall_data", data, p_data);
                chk("stall_row",  64'(row),  64'(p_row));
                chk("stall_col",  64'(col),  64'(p_col));
                chk("stall_last", 64'(last), 64'(p_last));
            end
            if (sb_en && vld && rdy) begin
                acc_cnt++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: unexpected beat data %0h", data);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", data, e.data);
                    chk("sb_row",  64'(row),  64'(e.row));
                    chk("sb_col",  64'(col),  64'(e.col));
                    chk("sb_last", 64'(last), 64'(e.last));
                end
            end
            stall_p = vld && !rdy;
            p_data  = data;
            p_row   = row;
            p_col   = col;
            p_last  = last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n   = 1'b0;
        c_valid = 1'b0;
        c_bus   = '0;
        rdy     = 1'b0;
        clr     = 1'b0;

`ifdef DRAIN_COL_MAJOR_EN
        tbl[0] = '{64'd1, 2'd0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{64'd4, 2'd1, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{64'd7, 2'd2, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{64'd2, 2'd0, 2'd1, 1'b0, 1'b0};
        tbl[4] = '{64'd5, 2'd1, 2'd1, 1'b0, 1'b0};
        tbl[5] = '{64'd8, 2'd2, 2'd1, 1'b0, 1'b0};
        tbl[6] = '{64'd3, 2'd0, 2'd2, 1'b0, 1'b0};
        tbl[7] = '{64'd6, 2'd1, 2'd2, 1'b0, 1'b0};
        tbl[8] = '{64'd9, 2'd2, 2'd2, 1'b1, 1'b1};
`else
        tbl[0] = '{64'd1, 2'd0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{64'd2, 2'd0, 2'd1, 1'b0, 1'b0};
        tbl[2] = '{64'd3, 2'd0, 2'd2, 1'b0, 1'b0};
        tbl[3] = '{64'd4, 2'd1, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{64'd5, 2'd1, 2'd1, 1'b0, 1'b0};
        tbl[5] = '{64'd6, 2'd1, 2'd2, 1'b0, 1'b0};
        tbl[6] = '{64'd7, 2'd2, 2'd0, 1'b0, 1'b0};
        tbl[7] = '{64'd8, 2'd2, 2'd1, 1'b0, 1'b0};
        tbl[8] = '{64'd9, 2'd2, 2'd2, 1'b1, 1'b1};
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(vld),     64'd0);
        chk("rst_last",    64'(last),    64'd0);
        chk("rst_data",    data,         64'd0);
        chk("rst_row",     64'(row),     64'd0);
        chk("rst_col",     64'(col),     64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_c_ready", 64'(c_ready), 64'd1);
        chk("idle_valid",   64'(vld),     64'd0);

        // Test 1: table-driven, one beat per clock with ready held high.
        rdy = 1'b1;
        capture(0);
        for (int j = 0; j < N*N; j++) begin
            @(negedge clk);
            chk($sformatf("t1_valid[%0d]", j),   64'(vld),     64'd1);
            chk($sformatf("t1_data[%0d]", j),    data,         tbl[j].data);
            chk($sformatf("t1_row[%0d]", j),     64'(row),     64'(tbl[j].row));
            chk($sformatf("t1_col[%0d]", j),     64'(col),     64'(tbl[j].col));
            chk($sformatf("t1_last[%0d]", j),    64'(last),    64'(tbl[j].last));
            chk($sformatf("t1_c_ready[%0d]", j), 64'(c_ready), 64'(tbl[j].c_ready));
        end
        @(negedge clk);
        chk("t1_end_valid",   64'(vld),     64'd0);
        chk("t1_end_c_ready", 64'(c_ready), 64'd1);

        // Test 2: ready toggles 1,0,1,0,...
        @(posedge clk); #1;
        sb_en   = 1'b1;
        acc_cnt = 0;
        push_matrix(0);
        capture(0);
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) begin
            @(posedge clk); #1;
            rdy = ~rdy;
        end
        if (sb_q.size() != 0) timeout_fail("t2_drain");
        rdy = 1'b1;
        @(negedge clk);
        chk("t2_accepted", 64'(acc_cnt), 64'd9);
        chk("t2_idle",     64'(vld),     64'd0);

        // Test 3: a new matrix arrives on the last-beat accept, with no bubble.
        @(posedge clk); #1;
        acc_cnt = 0;
        push_matrix(0);
        capture(0);
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (vld && last) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("t3_last");
        chk("t3_c_ready_last", 64'(c_ready), 64'd1);
        push_matrix(100);
        capture(100);
        @(negedge clk);
        chk("t3_no_gap_valid", 64'(vld), 64'd1);
        chk("t3_first_new",    data,     64'd101);
        wait_drain("t3_drain");
        chk("t3_overrun", 64'(overrun), 64'd0);
        chk("t3_count",   64'(acc_cnt), 64'd18);

        // Test 4: an offer mid-stream is ignored and sets the sticky overrun flag.
        push_matrix(0);
        capture(0);
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (vld && data == 64'd4) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("t4_beat4");
        chk("t4_c_ready_busy", 64'(c_ready), 64'd0);
        capture(100);
        @(negedge clk);
        chk("t4_overrun_set", 64'(overrun), 64'd1);
        wait_drain("t4_drain");
        chk("t4_overrun_held", 64'(overrun), 64'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t4_overrun_clr", 64'(overrun), 64'd0);

        // Test 4b: set and clear in the same cycle, where set takes priority.
        @(posedge clk); #1;
        push_matrix(0);
        capture(0);
        @(negedge clk);
        @(negedge clk);
        c_bus   = build(100);
        c_valid = 1'b1;
        clr     = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
        clr     = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", 64'(overrun), 64'd1);
        wait_drain("t4b_drain");
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t4b_overrun_clr", 64'(overrun), 64'd0);

        // Test 5: reset asserted mid-stream, then a fresh capture.
        @(posedge clk); #1;
        push_matrix(0);
        capture(0);
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (vld && data == 64'd5) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("t5_beat5");
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(vld),  64'd0);
        chk("t5_rst_row",   64'(row),  64'd0);
        chk("t5_rst_col",   64'(col),  64'd0);
        chk("t5_rst_data",  data,      64'd0);
        chk("t5_rst_last",  64'(last), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_c_ready", 64'(c_ready), 64'd1);
        push_matrix(0);
        capture(0);
        @(negedge clk);
        chk("t5_first", data, 64'd1);
        wait_drain("t5_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
